// File: rtl/apb_slave_regfile.sv
// APB register bank responder with a programmable number of wait states.
// Define APB_SLVERR_EN to flag out-of-range or unaligned accesses on Pslverr.
module apb_slave_regfile #(
   parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
   parameter int unsigned NUM_REGS    = 16,
   parameter int unsigned WAIT_STATES = 0
) (
   input  logic        Hclk,
   input  logic        Hresetn,
   input  logic        Psel,
   input  logic        Penable,
   input  logic        Pwrite,
   input  logic [31:0] Paddr,
   input  logic [31:0] Pwdata,
   output logic [31:0] Prdata,
   output logic        Pready,
   output logic        Pslverr
);
   localparam int unsigned IDX_W = $clog2(NUM_REGS);

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACCESS} state_t;

   state_t           state_q;
   logic [3:0]       cnt_q;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic             write_q;
   logic [31:0]      regs_q [NUM_REGS];
   logic [31:0]      prdata_q;
   logic             pready_q;
`ifdef APB_SLVERR_EN
   logic             slverr_q;
`endif

   logic             setup_d;
   logic             do_op_d;
   logic             op_write_d;
   logic             hit_d;
   logic [31:0]      op_addr_d;
   logic [31:0]      op_wdata_d;
   logic [31:0]      offset_d;
   logic [IDX_W-1:0] idx_d;

   // Zero-wait transfers act on the live bus at the setup edge; waited ones on the latched copy.
   always_comb begin
      setup_d = Psel & ~Penable;
      if (state_q == ST_WAIT) begin
         op_addr_d  = addr_q;
         op_write_d = write_q;
         op_wdata_d = wdata_q;
      end else begin
         op_addr_d  = Paddr;
         op_write_d = Pwrite;
         op_wdata_d = Pwdata;
      end
      offset_d = op_addr_d - BASE_ADDR;
      hit_d    = (offset_d[31:2] < 30'(NUM_REGS)) && (offset_d[1:0] == 2'b00);
      idx_d    = offset_d[IDX_W+1:2];
      do_op_d  = 1'b0;
      if (state_q == ST_WAIT) begin
         do_op_d = Psel && (cnt_q == 4'd1);
      end else if (WAIT_STATES == 0) begin
         do_op_d = setup_d;
      end
   end

   always_ff @(posedge Hclk or negedge Hresetn) begin
      if (!Hresetn) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         write_q  <= 1'b0;
         prdata_q <= '0;
         pready_q <= 1'b0;
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
`ifdef APB_SLVERR_EN
         slverr_q <= 1'b0;
`endif
      end else begin
         pready_q <= 1'b0;
`ifdef APB_SLVERR_EN
         slverr_q <= 1'b0;
`endif
         case (state_q)
            ST_WAIT: begin
               if (!Psel) begin
                  state_q <= ST_IDLE;
               end else begin
                  cnt_q <= cnt_q - 4'd1;
                  if (cnt_q == 4'd1) begin
                     state_q <= ST_ACCESS;
                  end
               end
            end
            default: begin
               state_q <= ST_IDLE;
               if (setup_d) begin
                  addr_q  <= Paddr;
                  write_q <= Pwrite;
                  wdata_q <= Pwdata;
                  if (WAIT_STATES == 0) begin
                     state_q <= ST_ACCESS;
                  end else begin
                     cnt_q   <= 4'(WAIT_STATES);
                     state_q <= ST_WAIT;
                  end
               end
            end
         endcase
         if (do_op_d) begin
            pready_q <= 1'b1;
            if (op_write_d) begin
               if (hit_d) begin
                  regs_q[idx_d] <= op_wdata_d;
               end
            end else begin
               prdata_q <= hit_d ? regs_q[idx_d] : '0;
            end
`ifdef APB_SLVERR_EN
            slverr_q <= ~hit_d;
`endif
         end
      end
   end

   assign Prdata = prdata_q;
   assign Pready = pready_q;
`ifdef APB_SLVERR_EN
   assign Pslverr = slverr_q;
`else
   assign Pslverr = 1'b0;
`endif

endmodule

// File: tb/tb_apb_slave_regfile.sv
// Bench for apb_slave_regfile: three instances (0, 2 and 3 wait states) share one APB bus
// and are checked cycle by cycle against a register-bank reference model.
module tb_apb_slave_regfile;
   localparam logic [31:0] BASE = 32'h8000_0000;
   localparam int unsigned WS_T [3] = '{0, 2, 3};
   localparam int unsigned MAXC = 4;
`ifdef APB_SLVERR_EN
   localparam bit SLVERR_EN = 1'b1;
`else
   localparam bit SLVERR_EN = 1'b0;
`endif

   logic        Hclk = 1'b0;
   logic        Hresetn = 1'b0;
   logic        Psel = 1'b0;
   logic        Penable = 1'b0;
   logic        Pwrite = 1'b0;
   logic [31:0] Paddr = '0;
   logic [31:0] Pwdata = '0;
   logic [31:0] prdata [3];
   logic        pready [3];
   logic        pslverr [3];

   int unsigned n_checks = 0;
   int unsigned n_fail = 0;

   logic [31:0] mem [3][16];
   logic [31:0] last_rd [3];
   logic [31:0] exp_rd [3];

   always #5 Hclk = ~Hclk;

   apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_STATES(0)) u_ws0 (
      .Hclk(Hclk), .Hresetn(Hresetn), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[0]), .Pready(pready[0]), .Pslverr(pslverr[0]));
   apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_STATES(2)) u_ws2 (
      .Hclk(Hclk), .Hresetn(Hresetn), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[1]), .Pready(pready[1]), .Pslverr(pslverr[1]));
   apb_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(16), .WAIT_STATES(3)) u_ws3 (
      .Hclk(Hclk), .Hresetn(Hresetn), .Psel(Psel), .Penable(Penable), .Pwrite(Pwrite),
      .Paddr(Paddr), .Pwdata(Pwdata), .Prdata(prdata[2]), .Pready(pready[2]), .Pslverr(pslverr[2]));

   typedef struct {
      logic        wr;
      logic [31:0] addr;
      logic [31:0] wdata;
      int unsigned abort_c;
      bit          corrupt;
      logic [31:0] rd_fast;
      logic [31:0] rd_slow;
      bit          miss;
   } vec_t;

   vec_t vecs [16];

   task automatic check(input string name, input int unsigned k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d (ws=%0d): actual %h required %h", name, k, WS_T[k], act, exp);
      end
   endtask

   function automatic bit model_hit(input logic [31:0] a);
      logic [31:0] off;
      off = a - BASE;
      return (off < 32'd64) && (a % 4 == 0);
   endfunction

   task automatic model_clear();
      for (int k = 0; k < 3; k++) begin
         last_rd[k] = '0;
         for (int i = 0; i < 16; i++) mem[k][i] = '0;
      end
   endtask

   // One transfer; abort_c drops Psel in that access cycle, corrupt alters Pwdata/Paddr after setup.
   task automatic xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                       input int unsigned abort_c, input bit corrupt, input bit miss);
      bit          done [3];
      bit          exp_rdy;
      int unsigned idx;
      for (int k = 0; k < 3; k++) done[k] = (abort_c == 0) || (WS_T[k] < abort_c);
      @(posedge Hclk); #1;
      Psel = 1'b1; Penable = 1'b0; Pwrite = wr; Paddr = addr; Pwdata = wdata;
      @(posedge Hclk); #1;
      Penable = 1'b1;
      if (corrupt) begin
         Pwdata = 32'hFFFF_FFFF;
         Paddr  = addr + 32'h10;
      end
      for (int unsigned c = 1; c <= MAXC; c++) begin
         if (c == abort_c) begin
            Psel = 1'b0; Penable = 1'b0;
         end
         @(negedge Hclk);
         for (int k = 0; k < 3; k++) begin
            exp_rdy = done[k] && (c == WS_T[k] + 1);
            check("pready", k, {31'b0, pready[k]}, {31'b0, exp_rdy});
            check("pslverr", k, {31'b0, pslverr[k]}, {31'b0, exp_rdy && miss && SLVERR_EN});
            if (exp_rdy && !wr) check("prdata", k, prdata[k], exp_rd[k]);
         end
         @(posedge Hclk); #1;
      end
      Psel = 1'b0; Penable = 1'b0;
      idx = (addr - BASE) / 4;
      for (int k = 0; k < 3; k++) begin
         if (done[k]) begin
            if (wr && !miss) mem[k][idx] = wdata;
            else if (!wr) last_rd[k] = miss ? 32'h0 : mem[k][idx];
         end
         check("prdata_hold", k, prdata[k], last_rd[k]);
      end
   endtask

   task automatic read_all_model();
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 3; k++) exp_rd[k] = mem[k][i];
         xfer(1'b0, BASE + 32'(i * 4), 32'h0, 0, 1'b0, 1'b0);
      end
   endtask

   initial begin
      logic [31:0] a;
      logic [31:0] d;
      logic        w;
      int unsigned r;
      int unsigned ab;

      vecs[0]  = '{1'b0, BASE + 32'h00, 32'h0,         0, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[1]  = '{1'b1, BASE + 32'h08, 32'hDEADBEEF,  0, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[2]  = '{1'b0, BASE + 32'h08, 32'h0,         0, 1'b0, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0};
      vecs[3]  = '{1'b1, BASE + 32'h0C, 32'h1234_5678, 0, 1'b1, 32'h0,         32'h0,         1'b0};
      vecs[4]  = '{1'b0, BASE + 32'h0C, 32'h0,         0, 1'b0, 32'h1234_5678, 32'h1234_5678, 1'b0};
      vecs[5]  = '{1'b1, BASE + 32'h40, 32'h1111_1111, 0, 1'b0, 32'h0,         32'h0,         1'b1};
      vecs[6]  = '{1'b1, BASE + 32'h06, 32'h2222_2222, 0, 1'b0, 32'h0,         32'h0,         1'b1};
      vecs[7]  = '{1'b1, BASE + 32'h04, 32'h3333_3333, 0, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[8]  = '{1'b1, BASE + 32'h04, 32'hA5A5_A5A5, 2, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[9]  = '{1'b0, BASE + 32'h04, 32'h0,         0, 1'b0, 32'hA5A5_A5A5, 32'h3333_3333, 1'b0};
      vecs[10] = '{1'b0, BASE + 32'h40, 32'h0,         0, 1'b0, 32'h0,         32'h0,         1'b1};
      vecs[11] = '{1'b0, BASE + 32'h3C, 32'h0,         0, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[12] = '{1'b0, BASE - 32'h04, 32'h0,         0, 1'b0, 32'h0,         32'h0,         1'b1};
      vecs[13] = '{1'b1, BASE + 32'h3C, 32'h0F0F_0F0F, 0, 1'b0, 32'h0,         32'h0,         1'b0};
      vecs[14] = '{1'b0, BASE + 32'h3C, 32'h0,         0, 1'b0, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b0};
      vecs[15] = '{1'b0, BASE + 32'h08, 32'h0,         0, 1'b0, 32'hDEADBEEF,  32'hDEADBEEF,  1'b0};

      model_clear();
      Hresetn = 1'b0;
      repeat (3) @(posedge Hclk);
      @(negedge Hclk);
      for (int k = 0; k < 3; k++) begin
         check("rst_prdata", k, prdata[k], 32'h0);
         check("rst_pready", k, {31'b0, pready[k]}, 32'h0);
         check("rst_pslverr", k, {31'b0, pslverr[k]}, 32'h0);
      end
      @(posedge Hclk); #1;
      Hresetn = 1'b1;

      for (int v = 0; v < 16; v++) begin
         exp_rd[0] = vecs[v].rd_fast;
         exp_rd[1] = vecs[v].rd_slow;
         exp_rd[2] = vecs[v].rd_slow;
         xfer(vecs[v].wr, vecs[v].addr, vecs[v].wdata, vecs[v].abort_c, vecs[v].corrupt,
              vecs[v].miss);
      end
      read_all_model();

      for (int n = 0; n < 80; n++) begin
         r = $urandom_range(0, 9);
         if (r < 7)       a = BASE + 32'($urandom_range(0, 15) * 4);
         else if (r == 7) a = BASE + 32'($urandom_range(0, 15) * 4 + $urandom_range(1, 3));
         else if (r == 8) a = BASE + 32'h40 + 32'($urandom_range(0, 15) * 4);
         else             a = 32'($urandom());
         w  = 1'($urandom_range(0, 1));
         d  = 32'($urandom());
         ab = $urandom_range(0, 9);
         ab = (ab > 5) ? ab - 5 : 0;
         for (int k = 0; k < 3; k++) exp_rd[k] = model_hit(a) ? mem[k][(a - BASE) / 4] : 32'h0;
         xfer(w, a, d, ab, 1'($urandom_range(0, 1)), !model_hit(a));
      end
      read_all_model();

      // Asynchronous reset in the middle of a write.
      @(posedge Hclk); #1;
      Psel = 1'b1; Penable = 1'b0; Pwrite = 1'b1; Paddr = BASE + 32'h10; Pwdata = 32'h5A5A_5A5A;
      @(posedge Hclk); #1;
      Penable = 1'b1;
      @(negedge Hclk);
      check("ready_before_rst", 0, {31'b0, pready[0]}, 32'h1);
      #2 Hresetn = 1'b0;
      #1;
      for (int k = 0; k < 3; k++) begin
         check("async_rst_pready", k, {31'b0, pready[k]}, 32'h0);
         check("async_rst_pslverr", k, {31'b0, pslverr[k]}, 32'h0);
         check("async_rst_prdata", k, prdata[k], 32'h0);
      end
      Psel = 1'b0; Penable = 1'b0;
      repeat (2) @(posedge Hclk);
      #1 Hresetn = 1'b1;
      model_clear();
      for (int i = 0; i < 16; i++) begin
         for (int k = 0; k < 3; k++) exp_rd[k] = 32'h0;
         xfer(1'b0, BASE + 32'(i * 4), 32'h0, 0, 1'b0, 1'b0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
